// File: rtl/stream_mux_rr.sv
// NCH-way valid/ready stream multiplexer with manual, fixed-priority and round-robin
// selection, feeding a one-entry registered output buffer that tags each beat's source.
module stream_mux_rr #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned NCH   = 4,
  parameter int unsigned SELW  = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [1:0]           mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_ch
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;

  logic             load_en;
  logic             grant_vld;
  logic [SELW-1:0]  grant_idx;
  logic             load;
  logic [WIDTH-1:0] grant_data;

  assign load_en = !out_valid_q || out_ready;

  // Round-robin picks the valid channel at the smallest forward distance from rr_ptr.
  always_comb begin
    int best;
    int d;
    grant_vld = 1'b0;
    grant_idx = '0;
    best      = int'(NCH);
    d         = 0;
    case (mode)
      2'd0: begin
        for (int i = 0; i < int'(NCH); i++) begin
          if (in_valid[i] && (sel == SELW'(i))) begin
            grant_vld = 1'b1;
            grant_idx = SELW'(i);
          end
        end
      end
      2'd1: begin
        for (int i = int'(NCH) - 1; i >= 0; i--) begin
          if (in_valid[i]) begin
            grant_vld = 1'b1;
            grant_idx = SELW'(i);
          end
        end
      end
      default: begin
        for (int i = 0; i < int'(NCH); i++) begin
          d = i - int'(rr_ptr_q);
          if (d < 0) d = d + int'(NCH);
          if (in_valid[i] && (d < best)) begin
            best      = d;
            grant_vld = 1'b1;
            grant_idx = SELW'(i);
          end
        end
      end
    endcase
  end

  always_comb begin
    in_ready   = '0;
    grant_data = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      in_ready[i] = resetn && load_en && grant_vld && (grant_idx == SELW'(i));
      if (grant_idx == SELW'(i)) grant_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign load = |(in_valid & in_ready);

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      out_data_d  = grant_data;
      out_ch_d    = grant_idx;
      out_valid_d = 1'b1;
      if (mode[1]) begin
        rr_ptr_d = (grant_idx == SELW'(NCH - 1)) ? '0 : grant_idx + SELW'(1);
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule
